// File: rtl/ifstage_fetch.sv
// ifstage_fetch: instruction-fetch stage for the single-cycle datapath.
//   Owns the program counter, issues word reads to instruction memory over a
//   req/ack handshake, holds the fetched word for the decoder and advances the
//   PC to PC+4 or the branch target when the decoder asserts PC_LdEn.
//
// Ports:
//   Clk, Reset        clock; synchronous active-high reset
//   PC_Sel            0: next PC = PC+4, 1: next PC = PC+4+(PC_Immed<<2)
//   PC_LdEn           retire the held instruction and advance the PC
//   PC_Immed[31:0]    sign-extended branch offset in words
//   IMem_Req          fetch request (state S_FETCH)
//   IMem_Addr         word address PC[IMEM_AW+1:2]
//   IMem_Ack          single-cycle acknowledge, IMem_Data valid with it
//   IMem_Data[31:0]   instruction word from memory
//   Instr[31:0]       held instruction word
//   Instr_Valid       Instr holds the instruction at PC (state S_HOLD)
//   PC[31:0]          current program counter
//   Fetch_Err         sticky fetch timeout
//
// Optional feature: define IFSTAGE_TIMEOUT_EN to enable the fetch timeout
// (S_ERR state, TIMEOUT_CYCLES counter). Without it Fetch_Err is tied to 0.

module ifstage_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned IMEM_AW        = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PC_Sel,
  input  logic               PC_LdEn,
  input  logic [31:0]        PC_Immed,
  output logic               IMem_Req,
  output logic [IMEM_AW-1:0] IMem_Addr,
  input  logic               IMem_Ack,
  input  logic [31:0]        IMem_Data,
  output logic [31:0]        Instr,
  output logic               Instr_Valid,
  output logic [31:0]        PC,
  output logic               Fetch_Err
);

`ifdef IFSTAGE_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] instr_q;
  logic        pc_load;
  logic        capture;

`ifdef IFSTAGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // Branch offset is in words; 32-bit modulo arithmetic, bits [1:0] stay 0.
  always_comb begin
    pc_next = pc_q + 32'd4;
    if (PC_Sel) begin
      pc_next = pc_q + 32'd4 + (PC_Immed << 2);
    end
  end

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        // An acknowledge in the terminal timeout cycle still wins.
        if (IMem_Ack) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
`ifdef IFSTAGE_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_next = S_ERR;
        end
`endif
      end
      S_HOLD: begin
        if (PC_LdEn) begin
          pc_load    = 1'b1;
          state_next = S_FETCH;
        end
      end
`ifdef IFSTAGE_TIMEOUT_EN
      S_ERR: state_next = S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
    end else begin
      state <= state_next;
      if (pc_load) begin
        pc_q <= pc_next;
      end
      if (capture) begin
        instr_q <= IMem_Data;
      end
    end
  end

`ifdef IFSTAGE_TIMEOUT_EN
  // Counter is zero whenever outside S_FETCH, so every entry starts from 0.
  always_ff @(posedge Clk) begin
    if (Reset || state != S_FETCH) begin
      cnt_q <= '0;
    end else if (!IMem_Ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Fetch_Err = (state == S_ERR);
`else
  assign Fetch_Err = 1'b0;
`endif

  assign IMem_Req    = (state == S_FETCH);
  assign IMem_Addr   = pc_q[IMEM_AW+1:2];
  assign Instr_Valid = (state == S_HOLD);
  assign Instr       = instr_q;
  assign PC          = pc_q;

endmodule

// File: tb/tb_ifstage_fetch.sv
// tb_ifstage_fetch: directed testbench for ifstage_fetch.
//   Drives the handshake and decoder controls by hand and compares every
//   output against hand-computed values. Timeout checks are compiled only
//   when IFSTAGE_TIMEOUT_EN is defined.

module tb_ifstage_fetch;

  localparam int unsigned AW = 10;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          PC_Sel;
  logic          PC_LdEn;
  logic [31:0]   PC_Immed;
  logic          IMem_Req;
  logic [AW-1:0] IMem_Addr;
  logic          IMem_Ack;
  logic [31:0]   IMem_Data;
  logic [31:0]   Instr;
  logic          Instr_Valid;
  logic [31:0]   PC;
  logic          Fetch_Err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ifstage_fetch #(
    .RESET_PC      (32'h0000_0000),
    .IMEM_AW       (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC_Sel     (PC_Sel),
    .PC_LdEn    (PC_LdEn),
    .PC_Immed   (PC_Immed),
    .IMem_Req   (IMem_Req),
    .IMem_Addr  (IMem_Addr),
    .IMem_Ack   (IMem_Ack),
    .IMem_Data  (IMem_Data),
    .Instr      (Instr),
    .Instr_Valid(Instr_Valid),
    .PC         (PC),
    .Fetch_Err  (Fetch_Err)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ack_with(input logic [31:0] data);
    IMem_Ack  = 1'b1;
    IMem_Data = data;
    tick();
    IMem_Ack  = 1'b0;
  endtask

  task automatic retire(input logic sel, input logic [31:0] immed);
    PC_LdEn  = 1'b1;
    PC_Sel   = sel;
    PC_Immed = immed;
    tick();
    PC_LdEn  = 1'b0;
    PC_Sel   = 1'b0;
    PC_Immed = '0;
  endtask

  initial begin
    Reset     = 1'b1;
    PC_Sel    = 1'b0;
    PC_LdEn   = 1'b0;
    PC_Immed  = '0;
    IMem_Ack  = 1'b0;
    IMem_Data = '0;
    tick();
    tick();

    // Reset state
    check_eq("rst_req",   32'(IMem_Req), 32'd0);
    check_eq("rst_valid", 32'(Instr_Valid), 32'd0);
    check_eq("rst_pc",    PC, 32'h0);
    check_eq("rst_instr", Instr, 32'h0);
    check_eq("rst_err",   32'(Fetch_Err), 32'd0);

    // First fetch, zero-wait acknowledge
    Reset = 1'b0;
    tick();
    check_eq("f1_req",   32'(IMem_Req), 32'd1);
    check_eq("f1_addr",  32'(IMem_Addr), 32'd0);
    check_eq("f1_valid", 32'(Instr_Valid), 32'd0);
    ack_with(32'h8000_0001);
    check_eq("f1_hvalid", 32'(Instr_Valid), 32'd1);
    check_eq("f1_instr",  Instr, 32'h8000_0001);
    check_eq("f1_pc",     PC, 32'h0);
    check_eq("f1_reqlo",  32'(IMem_Req), 32'd0);

    // Sequential advance up to PC = 0x10
    for (int i = 1; i <= 4; i++) begin
      retire(1'b0, 32'h0);
      check_eq("seq_pc",    PC, 32'(4 * i));
      check_eq("seq_valid", 32'(Instr_Valid), 32'd0);
      check_eq("seq_req",   32'(IMem_Req), 32'd1);
      ack_with(32'h1000_0000 + 32'(i));
    end

    // PC+4 from 0x10
    retire(1'b0, 32'h0);
    check_eq("inc_pc",   PC, 32'h14);
    check_eq("inc_addr", 32'(IMem_Addr), 32'd5);
    ack_with(32'h2000_0000);

    // Backward branch: 0x14 + 4 - 8 = 0x10
    retire(1'b1, 32'hFFFF_FFFE);
    check_eq("br_pc",   PC, 32'h10);
    check_eq("br_addr", 32'(IMem_Addr), 32'd4);

    // Acknowledge delayed by 5 cycles; decoder controls ignored in S_FETCH
    for (int k = 0; k < 5; k++) begin
      check_eq("dly_req",   32'(IMem_Req), 32'd1);
      check_eq("dly_addr",  32'(IMem_Addr), 32'd4);
      check_eq("dly_valid", 32'(Instr_Valid), 32'd0);
      PC_LdEn  = (k == 2);
      PC_Sel   = (k == 2);
      PC_Immed = 32'h0000_0100;
      tick();
      PC_LdEn  = 1'b0;
      PC_Sel   = 1'b0;
      PC_Immed = '0;
    end
    check_eq("dly_req6",  32'(IMem_Req), 32'd1);
    check_eq("dly_addr6", 32'(IMem_Addr), 32'd4);
    check_eq("dly_pc",    PC, 32'h10);
    ack_with(32'hDEAD_BEEF);
    check_eq("dly_hvalid", 32'(Instr_Valid), 32'd1);
    check_eq("dly_instr",  Instr, 32'hDEAD_BEEF);
    check_eq("dly_reqlo",  32'(IMem_Req), 32'd0);

    // Hold with spurious acknowledges
    for (int k = 0; k < 3; k++) begin
      IMem_Ack  = (k != 1);
      IMem_Data = 32'h1234_5678;
      tick();
      check_eq("hold_instr", Instr, 32'hDEAD_BEEF);
      check_eq("hold_pc",    PC, 32'h10);
      check_eq("hold_req",   32'(IMem_Req), 32'd0);
      check_eq("hold_valid", 32'(Instr_Valid), 32'd1);
    end
    IMem_Ack = 1'b0;
    tick();
    check_eq("hold_instr2", Instr, 32'hDEAD_BEEF);

    // Branch to the top of the address space: 0x14 - 24 = 0xFFFF_FFFC
    retire(1'b1, 32'hFFFF_FFFA);
    check_eq("top_pc",   PC, 32'hFFFF_FFFC);
    check_eq("top_addr", 32'(IMem_Addr), 32'h3FF);
    ack_with(32'h3000_0000);
    retire(1'b0, 32'h0);
    check_eq("wrap_pc",   PC, 32'h0);
    check_eq("wrap_addr", 32'(IMem_Addr), 32'd0);

    // Forward branch to 0x40, then reset while the fetch is outstanding
    ack_with(32'h4000_0000);
    retire(1'b1, 32'h0000_000F);
    check_eq("b40_pc",   PC, 32'h40);
    check_eq("b40_addr", 32'(IMem_Addr), 32'h10);
    check_eq("b40_req",  32'(IMem_Req), 32'd1);
    Reset = 1'b1;
    tick();
    check_eq("mrst_req", 32'(IMem_Req), 32'd0);
    check_eq("mrst_pc",  PC, 32'h0);
    Reset     = 1'b0;
    IMem_Ack  = 1'b1;
    IMem_Data = 32'h0BAD_0BAD;
    tick();
    IMem_Ack = 1'b0;
    check_eq("late_req",   32'(IMem_Req), 32'd1);
    check_eq("late_addr",  32'(IMem_Addr), 32'd0);
    check_eq("late_valid", 32'(Instr_Valid), 32'd0);
    check_eq("late_instr", Instr, 32'h0);
    tick();
    check_eq("late_valid2", 32'(Instr_Valid), 32'd0);
    check_eq("late_err",    32'(Fetch_Err), 32'd0);
    ack_with(32'h5555_AAAA);
    check_eq("post_instr", Instr, 32'h5555_AAAA);
    check_eq("post_valid", 32'(Instr_Valid), 32'd1);

`ifdef IFSTAGE_TIMEOUT_EN
    // Timeout: no acknowledge for 16 S_FETCH cycles
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    for (int k = 1; k < 16; k++) begin
      tick();
      check_eq("to_req",  32'(IMem_Req), 32'd1);
      check_eq("to_err0", 32'(Fetch_Err), 32'd0);
    end
    tick();
    check_eq("to_err",    32'(Fetch_Err), 32'd1);
    check_eq("to_reqlo",  32'(IMem_Req), 32'd0);
    IMem_Ack = 1'b1;
    PC_LdEn  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("to_sticky", 32'(Fetch_Err), 32'd1);
      check_eq("to_valid",  32'(Instr_Valid), 32'd0);
    end
    IMem_Ack = 1'b0;
    PC_LdEn  = 1'b0;
    Reset = 1'b1;
    tick();
    check_eq("to_clr", 32'(Fetch_Err), 32'd0);

    // Acknowledge in the terminal cycle wins
    Reset = 1'b0;
    tick();
    for (int k = 1; k < 16; k++) begin
      tick();
    end
    check_eq("term_req", 32'(IMem_Req), 32'd1);
    ack_with(32'h6666_7777);
    check_eq("term_valid", 32'(Instr_Valid), 32'd1);
    check_eq("term_instr", Instr, 32'h6666_7777);
    check_eq("term_err",   32'(Fetch_Err), 32'd0);
    tick();
    check_eq("term_err2",  32'(Fetch_Err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifstage_fetch.md
# ifstage_fetch

Instruction-fetch stage for the single-cycle datapath. It owns the program counter and issues word reads to the instruction memory over a request/acknowledge handshake. It presents each fetched word to the decoder as `Instr` with a valid flag, and consumes the decoder's `PC_Sel` / `PC_LdEn` to advance to PC+4 or to the branch target. It sits between the instruction memory and the control/decode logic, supplying the `Instr` those blocks decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset (word aligned).
- `IMEM_AW`, default 10: instruction-memory word-address width.
- `TIMEOUT_CYCLES`, default 16: maximum number of S_FETCH cycles without an acknowledge. Used only with `IFSTAGE_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous active-high reset.
- `PC_Sel`  in  1  0 = next PC is PC+4; 1 = next PC is the branch target.
- `PC_LdEn`  in  1  load enable; retires the held instruction and advances the PC.
- `PC_Immed`  in  32  sign-extended branch offset, in words.
- `IMem_Req`  out  1  fetch request.
- `IMem_Addr`  out  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
- `IMem_Ack`  in  1  single-cycle acknowledge; `IMem_Data` is valid in the same cycle.
- `IMem_Data`  in  32  instruction word.
- `Instr`  out  32  held instruction word.
- `Instr_Valid`  out  1  `Instr` holds the instruction at `PC`.
- `PC`  out  32  current program counter.
- `Fetch_Err`  out  1  sticky fetch timeout. Tied to 0 without `IFSTAGE_TIMEOUT_EN`.

## Operation
- The FSM has four states:
  - S_IDLE: entered on reset.
  - S_FETCH: request outstanding.
  - S_HOLD: instruction presented to the decoder.
  - S_ERR: fetch timed out; exists only with the macro.
- Outputs are decoded from registers only:
  - `IMem_Req` = (state == S_FETCH).
  - `IMem_Addr` is taken from the PC register.
  - `Instr_Valid` = (state == S_HOLD).
- Transitions:
  - S_IDLE goes to S_FETCH unconditionally on the next edge.
  - In S_FETCH, with `IMem_Ack`=1, the block captures `IMem_Data` into `Instr` and moves to S_HOLD. With `IMem_Ack`=0 it stays in S_FETCH; `IMem_Req` and `IMem_Addr` are held stable.
  - In S_HOLD, with `PC_LdEn`=1, the PC is updated and the FSM returns to S_FETCH. With `PC_LdEn`=0 it stays in S_HOLD and `Instr` is held.
- Next PC:
  - `PC_Sel`=0: PC + 4.
  - `PC_Sel`=1: PC + 4 + (`PC_Immed` << 2).
  - All arithmetic is 32-bit modulo; the PC wraps silently from 32'hFFFF_FFFC to 0. Bits [1:0] stay 0.
- Ignored inputs:
  - `PC_LdEn` and `PC_Sel` outside S_HOLD.
  - `IMem_Ack` outside S_FETCH, including a late acknowledge of a request abandoned by reset.
- `Instr` keeps its last value after `Instr_Valid` falls. It changes only on a captured acknowledge.
- Reset values: PC = `RESET_PC`, `Instr` = 0, `Instr_Valid` = 0, `IMem_Req` = 0, `Fetch_Err` = 0, state = S_IDLE.
- Reset mid-operation, whether in S_FETCH or S_HOLD: it wins over all other inputs. The in-flight request is abandoned and the held instruction is discarded.

## Timing
- After `Reset` is sampled low at edge 0, `IMem_Req` is 1 in cycle 1.
- A zero-wait acknowledge in cycle 1 gives `Instr_Valid`=1 in cycle 2.
- The minimum rate is 2 cycles per instruction: one S_FETCH cycle and one S_HOLD cycle.
- The PC update and the drop of `Instr_Valid` occur at the same edge that samples `PC_LdEn`=1. The new `IMem_Req` and `IMem_Addr` are valid in the following cycle.
- Each request receives exactly one acknowledge. `IMem_Req` falls in the cycle after the acknowledge.

## Configuration
- Macro: `IFSTAGE_TIMEOUT_EN`.
- When defined:
  - A counter is cleared on every entry to S_FETCH and increments on each S_FETCH cycle without an acknowledge.
  - If cycle number `TIMEOUT_CYCLES` in S_FETCH passes with no acknowledge, the FSM moves to S_ERR. In S_ERR, `Fetch_Err`=1 and `IMem_Req`=0.
  - S_ERR is left only by `Reset`.
  - An acknowledge arriving in the terminal cycle wins over the timeout.
- When not defined: there is no counter and no S_ERR state; the block waits for an acknowledge indefinitely; `Fetch_Err` is constant 0.

## Test plan
- Reset, then a zero-wait memory returning 32'h8000_0001 -> `IMem_Addr`=0 in cycle 1, `Instr`=32'h8000_0001 with `Instr_Valid`=1 in cycle 2, `PC`=0.
- In S_HOLD at PC=0x10, `PC_LdEn`=1, `PC_Sel`=0 -> `PC`=0x14, `IMem_Addr`=5.
- Then `PC_Sel`=1 with `PC_Immed`=32'hFFFF_FFFE -> `PC` = 0x14+4-8 = 0x10.
- Acknowledge delayed by 5 cycles -> `IMem_Req` and `IMem_Addr` stable for all 6 cycles; `Instr_Valid` stays 0 until the cycle after the acknowledge.
- Hold for 3 cycles with `PC_LdEn`=0 and spurious `IMem_Ack` pulses -> `Instr` and `PC` unchanged; no new request.
- `Reset` asserted in S_FETCH at PC=0x40, then a late acknowledge in S_IDLE -> acknowledge ignored, `PC`=`RESET_PC`, and the next fetch goes to word address 0.
- `IFSTAGE_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and no acknowledge -> `Fetch_Err`=1 and `IMem_Req`=0 after 16 S_FETCH cycles; `Fetch_Err` stays 1 until `Reset`.
- `IFSTAGE_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and an acknowledge in cycle 16 -> normal capture and `Fetch_Err`=0.
